wb_commit_queue: RTL

WB_COMMIT_QUEUE -- requirements
Module: wb_commit_queue

---
 rtl/mips_core_pkg.sv | 23 ++
 rtl/wbq_fwd_lookup.sv | 46 ++++
 rtl/wb_commit_queue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mips_core_pkg.sv
// Shared core definitions: write-back queue entry layout and default sizing.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package mips_core_pkg;

   localparam int WBQ_DEPTH   = 4;
   localparam int WBQ_DATA_W  = 32;
   localparam int WBQ_RADDR_W = 5;
   localparam int WBQ_ID_W    = `ADDR_WIDTH;

   // Field widths follow the package defaults; queue instances use the same sizing.
   typedef struct packed {
      logic [WBQ_ID_W-1:0]    id;
      logic                   uses_rw;
      logic [WBQ_RADDR_W-1:0] rw_addr;
      logic                   is_mem;
      logic                   complete;
      logic [WBQ_DATA_W-1:0]  data;
   } wbq_entry_t;

endpackage

// File: rtl/wbq_fwd_lookup.sv
// Youngest-producer search over the commit queue for decode-stage forwarding.
module wbq_fwd_lookup
   import mips_core_pkg::*;
#(
   parameter int DEPTH   = WBQ_DEPTH,
   parameter int DATA_W  = WBQ_DATA_W,
   parameter int RADDR_W = WBQ_RADDR_W
) (
   input  wbq_entry_t                 ent [DEPTH],
   input  logic [DEPTH-1:0]           occ,
   input  logic [$clog2(DEPTH)-1:0]   head,
   input  logic [RADDR_W-1:0]         fwd_addr,
   output logic                       fwd_hit,
   output logic [DATA_W-1:0]          fwd_data,
   output logic                       fwd_stall
);

   localparam int PW = $clog2(DEPTH);

   logic              match;
   logic              m_complete;
   logic [DATA_W-1:0] m_data;
   logic [PW-1:0]     slot;

   // Walk oldest to youngest so the last hit is the youngest producer.
   always_comb begin
      match      = 1'b0;
      m_complete = 1'b0;
      m_data     = '0;
      slot       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = head + PW'(k);
         if (occ[slot] && ent[slot].uses_rw && (ent[slot].rw_addr == fwd_addr)
             && (fwd_addr != '0)) begin
            match      = 1'b1;
            m_complete = ent[slot].complete;
            m_data     = ent[slot].data;
         end
      end
   end

   assign fwd_hit   = match & m_complete;
   assign fwd_stall = match & ~m_complete;
   assign fwd_data  = (match & m_complete) ? m_data : '0;

endmodule

// File: rtl/wb_commit_queue.sv
// In-order write-back commit queue with d-cache completion binding and forwarding.
module wb_commit_queue
   import mips_core_pkg::*;
#(
   parameter int DEPTH   = WBQ_DEPTH,
   parameter int DATA_W  = WBQ_DATA_W,
   parameter int RADDR_W = WBQ_RADDR_W,
   parameter int ID_W    = `ADDR_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ID_W-1:0]            in_id,
   input  logic                       in_uses_rw,
   input  logic [RADDR_W-1:0]         in_rw_addr,
   input  logic                       in_is_mem_access,
   input  logic [DATA_W-1:0]          in_alu_result,
   input  logic                       cache_valid,
   input  logic [DATA_W-1:0]          cache_data,
   output logic                       wb_valid,
   output logic                       wb_uses_rw,
   output logic [RADDR_W-1:0]         wb_rw_addr,
   output logic [DATA_W-1:0]          wb_rw_data,
   output logic [ID_W-1:0]            wb_id,
   input  logic [RADDR_W-1:0]         fwd_addr,
   output logic                       fwd_hit,
   output logic [DATA_W-1:0]          fwd_data,
   output logic                       fwd_stall,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       proto_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wbq_entry_t        ent [DEPTH];
   logic [DEPTH-1:0]  occ;
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [CW-1:0]     cnt;

   logic              do_enq;
   logic              bind_found;
   logic [PW-1:0]     bind_slot;
   logic [PW-1:0]     scan_slot;

   assign in_ready = (cnt < CW'(DEPTH));
   assign do_enq   = in_valid & in_ready & ~flush;
   assign count    = cnt;

   assign wb_valid   = occ[head] & ent[head].complete;
   assign wb_uses_rw = wb_valid & ent[head].uses_rw & (ent[head].rw_addr != '0);
   assign wb_rw_addr = wb_valid ? ent[head].rw_addr : '0;
   assign wb_rw_data = wb_valid ? ent[head].data    : '0;
   assign wb_id      = wb_valid ? ent[head].id      : '0;

   // Cache returns arrive in program order, so each binds to the oldest pending load.
   always_comb begin
      bind_found = 1'b0;
      bind_slot  = '0;
      scan_slot  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         scan_slot = head + PW'(k);
         if (!bind_found && occ[scan_slot] && ent[scan_slot].is_mem
             && !ent[scan_slot].complete) begin
            bind_found = 1'b1;
            bind_slot  = scan_slot;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ       <= '0;
         head      <= '0;
         tail      <= '0;
         cnt       <= '0;
         proto_err <= 1'b0;
         for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
      end else if (flush) begin
         occ  <= '0;
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (wb_valid) begin
            occ[head] <= 1'b0;
            head      <= head + 1'b1;
         end
         if (do_enq) begin
            ent[tail] <= '{id:       in_id,
                           uses_rw:  in_uses_rw,
                           rw_addr:  in_rw_addr,
                           is_mem:   in_is_mem_access,
                           complete: ~in_is_mem_access,
                           data:     in_is_mem_access ? '0 : in_alu_result};
            occ[tail] <= 1'b1;
            tail      <= tail + 1'b1;
         end
         if (cache_valid) begin
            if (bind_found) begin
               ent[bind_slot].data     <= cache_data;
               ent[bind_slot].complete <= 1'b1;
            end else begin
               proto_err <= 1'b1;
            end
         end
         cnt <= cnt + CW'(do_enq) - CW'(wb_valid);
      end
   end

   wbq_fwd_lookup #(
      .DEPTH   (DEPTH),
      .DATA_W  (DATA_W),
      .RADDR_W (RADDR_W)
   ) u_fwd (
      .ent       (ent),
      .occ       (occ),
      .head      (head),
      .fwd_addr  (fwd_addr),
      .fwd_hit   (fwd_hit),
      .fwd_data  (fwd_data),
      .fwd_stall (fwd_stall)
   );

endmodule
